pc_next_unit: RTL

Registered program-counter and next-PC selection unit for the MIPS-32 core. It generalises the single jump/next-address 2:1 select into a prioritised multi-source selector that covers sequential, branch, jump, jump-register and exception targets. It adds stall handling, with a pending-redirect buffer, and misaligned-target detection. It sits at the front of the fetch path and drives the instruction-memory address.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pc_target_mux.sv | 51 +++++
 rtl/pc_next_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-32 fetch front end:
// PC source encoding, fetch FSM states and the fixed vectors.
package mips_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int J_INDEX_W     = 26;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_J,
        SRC_JR,
        SRC_EXC
    } pc_src_e;

    typedef enum logic {
        RUN,
        HOLD
    } pc_state_e;

    // Only word-aligned fetch addresses are legal.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target formation and source priority encoder
// (exception > jump-register > jump > branch > sequential).
module pc_target_mux
    import mips_pkg::*;
#(
    parameter int          WIDTH      = WIDTH_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned STEP       = 4
) (
    input  logic [WIDTH-1:0]     pc_i,
    input  logic                 branch_taken_i,
    input  logic [15:0]          branch_imm_i,
    input  logic                 jump_sel_i,
    input  logic [J_INDEX_W-1:0] jump_index_i,
    input  logic                 jr_sel_i,
    input  logic [WIDTH-1:0]     jr_target_i,
    input  logic                 exc_i,
    output logic [WIDTH-1:0]     seq_o,
    output logic [WIDTH-1:0]     target_o,
    output pc_src_e              src_o
);

    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;

    assign seq_o     = pc_i + WIDTH'(STEP);
    assign br_off    = {{(WIDTH-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};
    assign br_target = seq_o + br_off;
    // Jump keeps the upper region bits of the delay-slot address.
    assign j_target  = {seq_o[WIDTH-1:28], jump_index_i, 2'b00};

    always_comb begin
        target_o = seq_o;
        src_o    = SRC_SEQ;
        if (exc_i) begin
            target_o = WIDTH'(EXC_VECTOR);
            src_o    = SRC_EXC;
        end else if (jr_sel_i) begin
            target_o = jr_target_i;
            src_o    = SRC_JR;
        end else if (jump_sel_i) begin
            target_o = j_target;
            src_o    = SRC_J;
        end else if (branch_taken_i) begin
            target_o = br_target;
            src_o    = SRC_BR;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered program counter with prioritised next-PC selection, a one-entry
// redirect buffer that survives stalls, and misaligned jump-register trapping.
module pc_next_unit
    import mips_pkg::*;
#(
    parameter int          WIDTH        = WIDTH_DEFAULT,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned STEP         = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [15:0]          i_branch_imm,
    input  logic                 i_jump_sel,
    input  logic [J_INDEX_W-1:0] i_jump_index,
    input  logic                 i_jr_sel,
    input  logic [WIDTH-1:0]     i_jr_target,
    input  logic                 i_exc,
    output logic [WIDTH-1:0]     o_pc,
    output logic [WIDTH-1:0]     o_pc_plus4,
    output logic                 o_redirect,
    output logic                 o_addr_err,
    output logic                 o_pending
);

    localparam logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_VECTOR);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic             addr_err_q, addr_err_d;
    logic [WIDTH-1:0] buf_target_q, buf_target_d;
    logic             buf_exc_q, buf_exc_d;
    logic             buf_jr_q, buf_jr_d;

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] mux_target;
    pc_src_e          mux_src;
    logic             mux_req;
    logic             mux_bad_jr;

    pc_target_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR),
        .STEP       (STEP)
    ) u_target_mux (
        .pc_i           (pc_q),
        .branch_taken_i (i_branch_taken),
        .branch_imm_i   (i_branch_imm),
        .jump_sel_i     (i_jump_sel),
        .jump_index_i   (i_jump_index),
        .jr_sel_i       (i_jr_sel),
        .jr_target_i    (i_jr_target),
        .exc_i          (i_exc),
        .seq_o          (seq),
        .target_o       (mux_target),
        .src_o          (mux_src)
    );

    assign mux_req    = (mux_src != SRC_SEQ);
    assign mux_bad_jr = (mux_src == SRC_JR) && misaligned(mux_target[1:0]);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        addr_err_d   = 1'b0;
        buf_target_d = buf_target_q;
        buf_exc_d    = buf_exc_q;
        buf_jr_d     = buf_jr_q;
        unique case (state_q)
            RUN: begin
                if (!i_stall) begin
                    pc_d       = mux_bad_jr ? EXC_ADDR : mux_target;
                    redirect_d = mux_req;
                    addr_err_d = mux_bad_jr;
                end else if (mux_req) begin
                    buf_target_d = mux_target;
                    buf_exc_d    = (mux_src == SRC_EXC);
                    buf_jr_d     = (mux_src == SRC_JR);
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (i_stall) begin
                    // An exception already in the buffer is never displaced.
                    if (mux_src == SRC_EXC || (mux_req && !buf_exc_q)) begin
                        buf_target_d = mux_target;
                        buf_exc_d    = (mux_src == SRC_EXC);
                        buf_jr_d     = (mux_src == SRC_JR);
                    end
                end else begin
                    if (i_exc) begin
                        pc_d = EXC_ADDR;
                    end else if (buf_jr_q && misaligned(buf_target_q[1:0])) begin
                        pc_d       = EXC_ADDR;
                        addr_err_d = 1'b1;
                    end else begin
                        pc_d = buf_target_q;
                    end
                    redirect_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_ADDR;
            redirect_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            buf_target_q <= '0;
            buf_exc_q    <= 1'b0;
            buf_jr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            addr_err_q   <= addr_err_d;
            buf_target_q <= buf_target_d;
            buf_exc_q    <= buf_exc_d;
            buf_jr_q     <= buf_jr_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = seq;
    assign o_redirect = redirect_q;
    assign o_addr_err = addr_err_q;
    assign o_pending  = (state_q == HOLD);

endmodule
